pulse_bcd_counter: RTL and testbench
====================================

# pulse_bcd_counter

Downstream stage of `counter10k`: counts its `reached` events into a four-digit BCD value, 0000–9999. Provides a run gate, a synchronous clear, a lap-hold display latch, and wrap/overflow reporting. It sits between the 10k prescaler and the board display logic. An optional multiplexed 7-segment driver can be compiled in.

## Interface
- `SCAN_DIV`, default 16: ticks per display digit slot. Used only with `SEG7_EN`. Legal range 2..65535.
- `tick`  in  1  clock, rising-edge active. Same clock that drives `counter10k`.
- `resetN`  in  1  asynchronous, active-low reset.
- `reached`  in  1  event input from `counter10k`. A rising edge is one count.
- `runCounter`  in  1  level input. 1 = counting enabled, 0 = count frozen.
- `clear`  in  1  synchronous clear of count, overflow and hold state.
- `holdLap`  in  1  lap button, already debounced. Each rising edge toggles the display between live and held.
- `bcdOut`  out  16  displayed value as four BCD digits, `[15:12]` thousands down to `[3:0]` units.
- `liveOut`  out  16  live BCD count, never held.
- `carryPulse`  out  1  one-tick pulse on wrap from 9999 to 0000.
- `overflow`  out  1  sticky wrap flag.
- `seg`  out  7  active-low segments, `{g,f,e,d,c,b,a}`. Present only with `SEG7_EN`.
- `anode`  out  4  active-low one-hot digit select. `anode[0]` is the units digit. Present only with `SEG7_EN`.

## Operation
- **Edge detect:** `reachedPrev` is registered every tick. An event is `reached & ~reachedPrev`. A sustained-high `reached` counts once.
- **Increment:** the count increments on an event when `runCounter`=1 and `clear`=0.
  - BCD ripple: a digit at 9 goes to 0 and carries into the next digit.
  - 9999 + 1 gives 0000, asserts `carryPulse` and sets `overflow`.
- **runCounter=0:** events are consumed and discarded. They are not queued for later.
- **clear=1:**
  - Forces count 0000, `overflow`=0 and hold FSM to LIVE.
  - Priority over increment and over a `holdLap` edge in the same tick.
  - `reachedPrev` and `holdPrev` keep updating normally.
- **Hold FSM**, states LIVE and HELD:
  - LIVE: `bcdOut` = `liveOut`. A `holdLap` rising edge captures `liveOut` into the hold register and moves to HELD.
  - HELD: `bcdOut` = hold register. The live count keeps running. A `holdLap` rising edge moves to LIVE.
  - Simultaneous count event and lap edge in LIVE: the captured value is the pre-increment count.
- **Reset values:**
  - Count 0000, hold register 0000, state LIVE, `carryPulse`=0, `overflow`=0.
  - `reachedPrev`=1, so a `reached` already high at reset release is not counted.
  - `holdPrev`=1.

## Timing
- Count latency: `reached` sampled high at edge n with `reachedPrev`=0 gives `liveOut` updated after edge n, visible during cycle n+1.
- Events on consecutive ticks need `reached` to return low between them. The maximum count rate is one per two ticks.
- `carryPulse` is high for exactly the one cycle after the wrapping edge.
- `overflow` rises in the same cycle as `carryPulse`.
- Lap capture: a `holdLap` edge at tick n freezes `bcdOut` from cycle n+1.
- `resetN` low clears all registers immediately, mid-count or mid-scan, with no `tick` required. Release is synchronous to the next `tick` edge.

## Configuration
- **`SEG7_EN` defined:**
  - A free-running scan counter wraps at `SCAN_DIV`-1, then advances the digit index 0→1→2→3→0.
  - `anode` has a single 0 at the current index. `seg` is the registered decode of that digit of `bcdOut`, so anode and seg change on the same edge.
  - Reset values: `anode`=4'b1110, `seg`=7'b1000000 (the "0" glyph), scan counter 0.
  - Codes 10–15 cannot occur. If decoded, they drive `seg`=7'b1111111 (blank).
- **`SEG7_EN` undefined:** `seg`, `anode` and the scan logic do not exist. All other behaviour is identical.

## Test plan
- Reset, then 12 one-tick `reached` pulses spaced 2 ticks apart with `runCounter`=1 → `bcdOut`=16'h0012, `overflow`=0.
- Preload count to 9998, then 2 events → 9999, then 0000. `carryPulse` is high for one cycle and `overflow` stays 1 afterwards. Then `clear`=1 for 1 tick → `overflow`=0.
- `reached` held high for 20 ticks → count +1 only. `runCounter`=0 with 5 events → count unchanged. Re-enable → next event counts +1.
- At count 0042, `holdLap` edge → `bcdOut` stays 0042 while 3 events bring `liveOut` to 0045. Second `holdLap` edge → `bcdOut`=0045.
- Same tick `clear`=1, a `reached` edge and a `holdLap` edge → count 0000, state LIVE. Assert `resetN`=0 between `tick` edges → all outputs at reset values immediately.
- With `SEG7_EN` and `SCAN_DIV`=4, `bcdOut`=1234 → `anode` cycles 1110, 1101, 1011, 0111 every 4 ticks, with `seg` = 4, 3, 2, 1 glyphs (0011001, 0110000, 0100100, 1111001).

Source files
------------

// File: rtl/pulse_bcd_counter.sv
// Four-digit BCD event counter with run gate, clear, lap-hold latch and wrap reporting.
// Define SEG7_EN to add the multiplexed active-low 7-segment driver (seg/anode).
module pulse_bcd_counter #(
  parameter int SCAN_DIV = 16
) (
  input  logic        tick,
  input  logic        resetN,
  input  logic        reached,
  input  logic        runCounter,
  input  logic        clear,
  input  logic        holdLap,
  output logic [15:0] bcdOut,
  output logic [15:0] liveOut,
  output logic        carryPulse,
  output logic        overflow
`ifdef SEG7_EN
  ,
  output logic [6:0]  seg,
  output logic [3:0]  anode
`endif
);

  if (SCAN_DIV < 2 || SCAN_DIV > 65535) begin : g_bad_scan_div
    $error("SCAN_DIV must be in 2..65535");
  end

  typedef enum logic {LIVE = 1'b0, HELD = 1'b1} hold_state_t;

  logic [15:0] count_reg;
  logic [15:0] count_next;
  logic [15:0] hold_reg;
  logic        reached_prev_reg;
  logic        hold_prev_reg;
  logic        carry_pulse_reg;
  logic        overflow_reg;
  hold_state_t state_reg;

  logic        count_event;
  logic        lap_edge;
  logic [4:0]  carry_chain;

  assign count_event    = reached & ~reached_prev_reg & runCounter;
  assign lap_edge       = holdLap & ~hold_prev_reg;
  assign carry_chain[0] = count_event;

  // Per-digit BCD ripple; carry_chain[4] marks the 9999 -> 0000 wrap.
  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    logic digit_at_nine;
    assign digit_at_nine = (count_reg[gi*4 +: 4] == 4'd9);
    assign count_next[gi*4 +: 4] = !carry_chain[gi] ? count_reg[gi*4 +: 4] :
                                   digit_at_nine    ? 4'd0 :
                                                      4'(count_reg[gi*4 +: 4] + 4'd1);
    assign carry_chain[gi+1] = carry_chain[gi] & digit_at_nine;
  end

  always_ff @(posedge tick or negedge resetN) begin
    if (!resetN) begin
      count_reg        <= 16'h0000;
      hold_reg         <= 16'h0000;
      reached_prev_reg <= 1'b1;
      hold_prev_reg    <= 1'b1;
      carry_pulse_reg  <= 1'b0;
      overflow_reg     <= 1'b0;
      state_reg        <= LIVE;
    end else begin
      reached_prev_reg <= reached;
      hold_prev_reg    <= holdLap;
      carry_pulse_reg  <= 1'b0;
      if (clear) begin
        count_reg    <= 16'h0000;
        overflow_reg <= 1'b0;
        state_reg    <= LIVE;
      end else begin
        count_reg <= count_next;
        if (carry_chain[4]) begin
          carry_pulse_reg <= 1'b1;
          overflow_reg    <= 1'b1;
        end
        // Capture uses count_reg, so a same-tick count event is not included.
        case (state_reg)
          LIVE: if (lap_edge) begin
            hold_reg  <= count_reg;
            state_reg <= HELD;
          end
          HELD: if (lap_edge) state_reg <= LIVE;
          default: state_reg <= LIVE;
        endcase
      end
    end
  end

  assign liveOut    = count_reg;
  assign bcdOut     = (state_reg == HELD) ? hold_reg : count_reg;
  assign carryPulse = carry_pulse_reg;
  assign overflow   = overflow_reg;

`ifdef SEG7_EN
  logic [15:0] scan_cnt_reg;
  logic [1:0]  digit_idx_reg;
  logic [1:0]  digit_idx_next;
  logic        scan_last;
  logic [6:0]  seg_reg;
  logic [3:0]  anode_reg;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  assign scan_last      = (scan_cnt_reg == 16'(SCAN_DIV - 1));
  assign digit_idx_next = scan_last ? 2'(digit_idx_reg + 2'd1) : digit_idx_reg;

  // anode and seg both register from digit_idx_next so they switch on the same edge.
  always_ff @(posedge tick or negedge resetN) begin
    if (!resetN) begin
      scan_cnt_reg  <= 16'd0;
      digit_idx_reg <= 2'd0;
      anode_reg     <= 4'b1110;
      seg_reg       <= 7'b1000000;
    end else begin
      scan_cnt_reg  <= scan_last ? 16'd0 : 16'(scan_cnt_reg + 16'd1);
      digit_idx_reg <= digit_idx_next;
      anode_reg     <= ~(4'b0001 << digit_idx_next);
      seg_reg       <= seg_decode(bcdOut[digit_idx_next*4 +: 4]);
    end
  end

  assign seg   = seg_reg;
  assign anode = anode_reg;
`endif

endmodule

// File: tb/tb_pulse_bcd_counter.sv
// Self-checking bench for pulse_bcd_counter: vector table, directed corner sequences,
// and randomized traffic against an integer-arithmetic reference model.
module tb_pulse_bcd_counter;

  logic        tick = 1'b0;
  logic        resetN;
  logic        reached;
  logic        runCounter;
  logic        clear;
  logic        holdLap;
  logic [15:0] bcdOut;
  logic [15:0] liveOut;
  logic        carryPulse;
  logic        overflow;
`ifdef SEG7_EN
  logic [6:0]  seg;
  logic [3:0]  anode;
`endif

  int checks   = 0;
  int failures = 0;

  pulse_bcd_counter #(.SCAN_DIV(4)) dut (
    .tick       (tick),
    .resetN     (resetN),
    .reached    (reached),
    .runCounter (runCounter),
    .clear      (clear),
    .holdLap    (holdLap),
    .bcdOut     (bcdOut),
    .liveOut    (liveOut),
    .carryPulse (carryPulse),
    .overflow   (overflow)
`ifdef SEG7_EN
    ,
    .seg        (seg),
    .anode      (anode)
`endif
  );

  always #5 tick = ~tick;

  // Reference model: plain integer count plus a held flag.
  int m_count, m_hold;
  bit m_held, m_ovf, m_carry, m_prev_r, m_prev_lap;

  function automatic logic [15:0] to_bcd(input int n);
    to_bcd = {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  task automatic model_reset();
    m_count = 0; m_hold = 0; m_held = 0; m_ovf = 0; m_carry = 0;
    m_prev_r = 1; m_prev_lap = 1;
  endtask

  task automatic model_tick(input bit r, input bit run, input bit clr, input bit lap);
    bit ev, lev;
    int old;
    ev = r && !m_prev_r;
    lev = lap && !m_prev_lap;
    old = m_count;
    m_carry = 0;
    if (clr) begin
      m_count = 0; m_ovf = 0; m_held = 0;
    end else begin
      if (ev && run) begin
        m_count = (m_count + 1) % 10000;
        if (m_count == 0) begin m_carry = 1; m_ovf = 1; end
      end
      if (lev) begin
        if (!m_held) begin m_hold = old; m_held = 1; end
        else m_held = 0;
      end
    end
    m_prev_r = r; m_prev_lap = lap;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit run, input bit clr, input bit lap);
    reached = r; runCounter = run; clear = clr; holdLap = lap;
    @(posedge tick);
    model_tick(r, run, clr, lap);
    @(negedge tick);
    chk("model_live",  32'(liveOut),    32'(to_bcd(m_count)));
    chk("model_bcd",   32'(bcdOut),     32'(to_bcd(m_held ? m_hold : m_count)));
    chk("model_carry", 32'(carryPulse), 32'(m_carry));
    chk("model_ovf",   32'(overflow),   32'(m_ovf));
  endtask

  task automatic pulse(input int n, input bit run);
    for (int k = 0; k < n; k++) begin
      step(1, run, 0, 0);
      step(0, run, 0, 0);
    end
  endtask

  typedef struct {
    bit          r, run, clr, lap;
    logic [15:0] exp_live, exp_bcd;
    bit          exp_carry, exp_ovf;
  } vec_t;

  vec_t tbl[16];

`ifdef SEG7_EN
  logic [6:0] glyph[4];
  logic [3:0] an_exp[4];
`endif

  initial begin
    tbl[0]  = '{1, 1, 0, 0, 16'h0000, 16'h0000, 0, 0}; // high at release: ignored
    tbl[1]  = '{0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0};
    tbl[2]  = '{1, 1, 0, 0, 16'h0001, 16'h0001, 0, 0};
    tbl[3]  = '{0, 1, 0, 0, 16'h0001, 16'h0001, 0, 0};
    tbl[4]  = '{1, 0, 0, 0, 16'h0001, 16'h0001, 0, 0}; // gated off
    tbl[5]  = '{0, 1, 0, 0, 16'h0001, 16'h0001, 0, 0};
    tbl[6]  = '{1, 1, 0, 1, 16'h0002, 16'h0001, 0, 0}; // lap captures pre-increment
    tbl[7]  = '{0, 1, 0, 0, 16'h0002, 16'h0001, 0, 0};
    tbl[8]  = '{1, 1, 0, 0, 16'h0003, 16'h0001, 0, 0};
    tbl[9]  = '{0, 1, 0, 1, 16'h0003, 16'h0003, 0, 0}; // back to live
    tbl[10] = '{1, 1, 1, 0, 16'h0000, 16'h0000, 0, 0};
    tbl[11] = '{0, 1, 0, 1, 16'h0000, 16'h0000, 0, 0}; // held at 0
    tbl[12] = '{0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0};
    tbl[13] = '{1, 1, 1, 1, 16'h0000, 16'h0000, 0, 0}; // clear beats event and lap
    tbl[14] = '{0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0};
    tbl[15] = '{1, 1, 0, 0, 16'h0001, 16'h0001, 0, 0}; // proves state is LIVE

    resetN = 0; reached = 1; runCounter = 1; clear = 0; holdLap = 0;
    model_reset();
    #2;
    chk("reset_live",  32'(liveOut),    32'h0);
    chk("reset_bcd",   32'(bcdOut),     32'h0);
    chk("reset_carry", 32'(carryPulse), 32'h0);
    chk("reset_ovf",   32'(overflow),   32'h0);
    @(negedge tick); @(negedge tick);
    resetN = 1;

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].r, tbl[i].run, tbl[i].clr, tbl[i].lap);
      chk($sformatf("tbl%0d_live", i),  32'(liveOut),    32'(tbl[i].exp_live));
      chk($sformatf("tbl%0d_bcd", i),   32'(bcdOut),     32'(tbl[i].exp_bcd));
      chk($sformatf("tbl%0d_carry", i), 32'(carryPulse), 32'(tbl[i].exp_carry));
      chk($sformatf("tbl%0d_ovf", i),   32'(overflow),   32'(tbl[i].exp_ovf));
    end

    // Twelve spaced pulses from zero.
    step(0, 1, 1, 0);
    pulse(12, 1);
    chk("twelve_bcd", 32'(bcdOut), 32'h0012);
    chk("twelve_ovf", 32'(overflow), 32'h0);

    // Sustained high counts once; gated events are dropped.
    for (int k = 0; k < 20; k++) step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("sustain_live", 32'(liveOut), 32'h0013);
    pulse(5, 0);
    chk("gated_live", 32'(liveOut), 32'h0013);
    pulse(1, 1);
    chk("reenable_live", 32'(liveOut), 32'h0014);

    // Lap hold at 0042.
    pulse(28, 1);
    chk("lap_pre", 32'(liveOut), 32'h0042);
    step(0, 1, 0, 1);
    pulse(3, 1);
    chk("lap_held_bcd",  32'(bcdOut),  32'h0042);
    chk("lap_held_live", 32'(liveOut), 32'h0045);
    step(0, 1, 0, 0);
    step(0, 1, 0, 1);
    chk("lap_release_bcd", 32'(bcdOut), 32'h0045);
    step(0, 1, 0, 0);

    // Wrap at 9999.
    step(0, 1, 1, 0);
    pulse(9998, 1);
    chk("preload", 32'(liveOut), 32'h9998);
    pulse(1, 1);
    chk("at_9999", 32'(liveOut), 32'h9999);
    chk("no_carry_9999", 32'(carryPulse), 32'h0);
    step(1, 1, 0, 0);
    chk("wrap_live",  32'(liveOut),    32'h0000);
    chk("wrap_carry", 32'(carryPulse), 32'h1);
    chk("wrap_ovf",   32'(overflow),   32'h1);
    step(0, 1, 0, 0);
    chk("carry_one_cycle", 32'(carryPulse), 32'h0);
    chk("ovf_sticky",      32'(overflow),   32'h1);
    pulse(2, 1);
    chk("ovf_sticky2", 32'(overflow), 32'h1);
    step(0, 1, 1, 0);
    chk("clear_ovf", 32'(overflow), 32'h0);

    // Async reset mid-cycle while held with a nonzero count.
    pulse(7, 1);
    step(0, 1, 0, 1);
    pulse(2, 1);
    #2;
    resetN = 0; reached = 1;
    #1;
    chk("async_live",  32'(liveOut),    32'h0);
    chk("async_bcd",   32'(bcdOut),     32'h0);
    chk("async_carry", 32'(carryPulse), 32'h0);
    chk("async_ovf",   32'(overflow),   32'h0);
`ifdef SEG7_EN
    chk("async_anode", 32'(anode), 32'hE);
    chk("async_seg",   32'(seg),   32'h40);
`endif
    model_reset();
    @(negedge tick);
    resetN = 1;
    step(1, 1, 0, 0);
    chk("release_high_ignored", 32'(liveOut), 32'h0);
    step(0, 1, 0, 0);

`ifdef SEG7_EN
    glyph[0] = 7'b0011001; glyph[1] = 7'b0110000; glyph[2] = 7'b0100100; glyph[3] = 7'b1111001;
    an_exp[0] = 4'b1110; an_exp[1] = 4'b1101; an_exp[2] = 4'b1011; an_exp[3] = 4'b0111;
    step(0, 1, 1, 0);
    pulse(1234, 1);
    begin
      bit found;
      logic [3:0] prev_an;
      found = 0;
      prev_an = anode;
      for (int k = 0; k < 64 && !found; k++) begin
        step(0, 1, 0, 0);
        if (prev_an == 4'b0111 && anode == 4'b1110) found = 1;
        prev_an = anode;
      end
      chk("scan_sync_found", 32'(found), 32'h1);
      for (int d = 0; d < 4; d++) begin
        for (int k = 0; k < 4; k++) begin
          chk($sformatf("scan_anode_d%0d_k%0d", d, k), 32'(anode), 32'(an_exp[d]));
          chk($sformatf("scan_seg_d%0d_k%0d", d, k),   32'(seg),   32'(glyph[d]));
          step(0, 1, 0, 0);
        end
      end
    end
`endif

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 47) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
